// File: rtl/mem_stage_lsu_pkg.sv
// Shared decode constants, the data-memory command payload and small decode helpers
// for the MEM stage.
package mem_stage_lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [3:0]      be;
      logic [XLEN-1:0] wdata;
   } dmem_cmd_t;

   function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
      if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b01:   return a[0];
         2'b10:   return a != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, load lane
// extraction with sign/zero extension.
module mem_lane_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]      f3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] sdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] ldata
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      be    = 4'b1111;
      wdata = sdata;
      case (f3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{sdata[7:0]}};
         end
         2'b01: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{sdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_v = rdata[{addr_lo, 3'b000} +: 8];
      half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
      case (f3)
         F3_B:    ldata = {{24{byte_v[7]}}, byte_v};
         F3_H:    ldata = {{16{half_v[15]}}, half_v};
         F3_BU:   ldata = {24'h0, byte_v};
         F3_HU:   ldata = {16'h0, half_v};
         default: ldata = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: retires non-memory ops in one cycle and runs loads/stores on a req/ack
// data bus, stalling IF-EX while the access is outstanding.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_next_i_mem,
   input  logic [XLEN-1:0] alu_i_mem,
   input  logic [XLEN-1:0] data_i_mem,
   input  logic [4:0]      wbaddr_now_i_mem,
   input  logic [XLEN-1:0] instr_i_mem,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_o,
   output logic [XLEN-1:0] wbdata_o_wb,
   output logic [4:0]      wbaddr_o_wb,
   output logic            wben_o_wb,
   output logic [XLEN-1:0] instr_o_wb,
   output logic            misalign_o,
   output logic            buserr_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall_c, start_c, done_c, tmo_c;
   dmem_cmd_t        cmd_q;
   logic [2:0]       f3_q;
   logic [1:0]       a_q;
   logic [4:0]       rd_q;
   logic [XLEN-1:0]  instr_q;

   logic [6:0] opc;
   logic [2:0] f3;
   logic       bubble, is_ld, is_st, mem_op, mis, wr_rd;
   logic [3:0] be_c;
   logic [XLEN-1:0] wdata_c, ldata_c;

   // Instruction decode for the op currently sitting in EX/MEM
   always_comb begin
      opc    = instr_i_mem[6:0];
      f3     = instr_i_mem[14:12];
      bubble = (instr_i_mem == 32'h0000_0000) || (instr_i_mem == 32'h0000_0013);
      is_ld  = !bubble && (opc == OPC_LOAD)  && f3_valid(1'b0, f3);
      is_st  = !bubble && (opc == OPC_STORE) && f3_valid(1'b1, f3);
      mem_op = is_ld || is_st;
      mis    = mem_op && misaligned(f3, alu_i_mem[1:0]);
      wr_rd  = !bubble && writes_rd(opc) && (opc != OPC_LOAD) && (wbaddr_now_i_mem != 5'd0);
   end

   // Lane logic serves the live store in IDLE and the latched load in REQ
   mem_lane_align u_lane (
      .f3      (state_q == S_REQ ? f3_q : f3),
      .addr_lo (state_q == S_REQ ? a_q : alu_i_mem[1:0]),
      .sdata   (data_i_mem),
      .rdata   (dmem_rdata),
      .be      (be_c),
      .wdata   (wdata_c),
      .ldata   (ldata_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = 1'b0;
      start_c = 1'b0;
      done_c  = 1'b0;
      tmo_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_op && !mis) begin
               stall_c = 1'b1;
               start_c = 1'b1;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (dmem_ack) begin
               done_c  = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               tmo_c   = 1'b1;
               state_d = S_IDLE;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stall_o    = stall_c && !rst;
   assign dmem_we    = cmd_q.we;
   assign dmem_addr  = cmd_q.addr;
   assign dmem_be    = cmd_q.be;
   assign dmem_wdata = cmd_q.wdata;

   // Request latch and MEM/WB register; wben and the error pulses last one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req    <= 1'b0;
         cmd_q       <= '0;
         f3_q        <= '0;
         a_q         <= '0;
         rd_q        <= '0;
         instr_q     <= '0;
         wbdata_o_wb <= '0;
         wbaddr_o_wb <= '0;
         wben_o_wb   <= 1'b0;
         instr_o_wb  <= '0;
         misalign_o  <= 1'b0;
         buserr_o    <= 1'b0;
      end else begin
         wben_o_wb  <= 1'b0;
         misalign_o <= 1'b0;
         buserr_o   <= 1'b0;
         if (start_c) begin
            dmem_req <= 1'b1;
            cmd_q    <= dmem_cmd_t'{we:    is_st,
                                    addr:  {alu_i_mem[XLEN-1:2], 2'b00},
                                    be:    is_st ? be_c : 4'b1111,
                                    wdata: is_st ? wdata_c : '0};
            f3_q     <= f3;
            a_q      <= alu_i_mem[1:0];
            rd_q     <= wbaddr_now_i_mem;
            instr_q  <= instr_i_mem;
         end else if (state_q == S_IDLE) begin
            wbdata_o_wb <= (opc == OPC_JAL || opc == OPC_JALR) ? pc_next_i_mem : alu_i_mem;
            wbaddr_o_wb <= wbaddr_now_i_mem;
            wben_o_wb   <= wr_rd && !mis;
            instr_o_wb  <= instr_i_mem;
            misalign_o  <= mis;
         end else if (done_c || tmo_c) begin
            dmem_req    <= 1'b0;
            cmd_q       <= '0;
            wbdata_o_wb <= (done_c && !cmd_q.we) ? ldata_c : '0;
            wbaddr_o_wb <= rd_q;
            wben_o_wb   <= done_c && !cmd_q.we && (rd_q != 5'd0);
            instr_o_wb  <= instr_q;
            buserr_o    <= tmo_c;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for the MEM stage: ALU/JAL retire, loads/stores with wait states,
// misalignment, bus timeout and reset during an outstanding request.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_next_i_mem, alu_i_mem, data_i_mem, instr_i_mem;
   logic [4:0]  wbaddr_now_i_mem;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        stall_o, wben_o_wb, misalign_o, buserr_o;
   logic [31:0] wbdata_o_wb, instr_o_wb;
   logic [4:0]  wbaddr_o_wb;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .pc_next_i_mem(pc_next_i_mem), .alu_i_mem(alu_i_mem), .data_i_mem(data_i_mem),
      .wbaddr_now_i_mem(wbaddr_now_i_mem), .instr_i_mem(instr_i_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall_o(stall_o), .wbdata_o_wb(wbdata_o_wb), .wbaddr_o_wb(wbaddr_o_wb),
      .wben_o_wb(wben_o_wb), .instr_o_wb(instr_o_wb), .misalign_o(misalign_o),
      .buserr_o(buserr_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {17'h0, f3, rd, opc};
   endfunction

   // One non-memory op: must not stall, WB visible after the next edge
   task automatic alu_op(input logic [31:0] ins, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc);
      instr_i_mem = ins; wbaddr_now_i_mem = rd; alu_i_mem = alu; pc_next_i_mem = pc;
      #1 chk("alu_nostall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
   endtask

   // Memory op with a responder that acks after 'waits' REQ cycles (negative = never)
   task automatic mem_op(input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] sd, input int waits, input logic [31:0] word,
                         output int stalls, output logic seen, output logic [31:0] a_s,
                         output logic [3:0] be_s, output logic [31:0] wd_s, output logic we_s);
      logic st, fin;
      instr_i_mem = ins; wbaddr_now_i_mem = rd; alu_i_mem = addr; data_i_mem = sd;
      stalls = 0; seen = 1'b0; a_s = '0; be_s = '0; wd_s = '0; we_s = 1'b0; fin = 1'b0;
      for (int c = 0; c < 64 && !fin; c++) begin
         dmem_ack   = (waits >= 0) && (c == waits + 1);
         dmem_rdata = dmem_ack ? word : 32'h0;
         #1;
         st = stall_o;
         if (st) stalls++;
         if (dmem_req && !seen) begin
            seen = 1'b1; a_s = dmem_addr; be_s = dmem_be; wd_s = dmem_wdata; we_s = dmem_we;
         end
         @(posedge clk); #1;
         if (!st) fin = 1'b1;
      end
      if (!fin) chk("mem_op_bound", 32'd0, 32'd1);
      instr_i_mem = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
   endtask

   int          stl;
   logic        seen, we_s;
   logic [31:0] a_s, wd_s;
   logic [3:0]  be_s;

   initial begin
      rst = 1'b1; pc_next_i_mem = '0; alu_i_mem = '0; data_i_mem = '0;
      wbaddr_now_i_mem = '0; instr_i_mem = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_wbdata", wbdata_o_wb, 32'd0);
      chk("rst_wben", 32'(wben_o_wb), 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_flags", {30'd0, misalign_o, buserr_o}, 32'd0);
      rst = 1'b0;

      // ADD rd=5
      alu_op(enc(7'b0110011, 3'b000, 5'd5), 5'd5, 32'h1234, 32'h8);
      chk("add_wbdata", wbdata_o_wb, 32'h1234);
      chk("add_wbaddr", 32'(wbaddr_o_wb), 32'd5);
      chk("add_wben", 32'(wben_o_wb), 32'd1);

      // LB rd=7 @0x103, two wait cycles
      mem_op(enc(7'b0000011, 3'b000, 5'd7), 5'd7, 32'h103, 32'h0, 2, 32'h80FF_FF00,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("lb_stalls", 32'(stl), 32'd3);
      chk("lb_addr", a_s, 32'h100);
      chk("lb_be", 32'(be_s), 32'hF);
      chk("lb_we", 32'(we_s), 32'd0);
      chk("lb_wbdata", wbdata_o_wb, 32'hFFFF_FF80);
      chk("lb_wben", 32'(wben_o_wb), 32'd1);
      chk("lb_wbaddr", 32'(wbaddr_o_wb), 32'd7);
      @(posedge clk); #1;
      chk("lb_wben_once", 32'(wben_o_wb), 32'd0);

      mem_op(enc(7'b0000011, 3'b100, 5'd7), 5'd7, 32'h103, 32'h0, 2, 32'h80FF_FF00,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("lbu_wbdata", wbdata_o_wb, 32'h0000_0080);

      mem_op(enc(7'b0000011, 3'b001, 5'd9), 5'd9, 32'h102, 32'h0, 0, 32'h80FF_FF00,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("lh_stalls", 32'(stl), 32'd1);
      chk("lh_wbdata", wbdata_o_wb, 32'hFFFF_80FF);

      mem_op(enc(7'b0000011, 3'b101, 5'd9), 5'd9, 32'h100, 32'h0, 1, 32'h80FF_FF00,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("lhu_wbdata", wbdata_o_wb, 32'h0000_FF00);

      // SH @0x102 and SB @0x101
      mem_op(enc(7'b0100011, 3'b001, 5'd0), 5'd0, 32'h102, 32'h0000_ABCD, 0, 32'h0,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("sh_addr", a_s, 32'h100);
      chk("sh_be", 32'(be_s), 32'hC);
      chk("sh_wdata", wd_s, 32'hABCD_ABCD);
      chk("sh_we", 32'(we_s), 32'd1);
      chk("sh_wben", 32'(wben_o_wb), 32'd0);

      mem_op(enc(7'b0100011, 3'b000, 5'd0), 5'd0, 32'h101, 32'h1234_565A, 1, 32'h0,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("sb_be", 32'(be_s), 32'h2);
      chk("sb_wdata", wd_s, 32'h5A5A_5A5A);

      // LW misaligned
      mem_op(enc(7'b0000011, 3'b010, 5'd3), 5'd3, 32'h101, 32'h0, 0, 32'h0,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("mis_req", 32'(seen), 32'd0);
      chk("mis_stalls", 32'(stl), 32'd0);
      chk("mis_flag", 32'(misalign_o), 32'd1);
      chk("mis_wben", 32'(wben_o_wb), 32'd0);
      @(posedge clk); #1;
      chk("mis_pulse", 32'(misalign_o), 32'd0);

      // LW never acked
      mem_op(enc(7'b0000011, 3'b010, 5'd4), 5'd4, 32'h104, 32'h0, -1, 32'h0,
             stl, seen, a_s, be_s, wd_s, we_s);
      chk("tmo_stalls", 32'(stl), 32'd16);
      chk("tmo_buserr", 32'(buserr_o), 32'd1);
      chk("tmo_wben", 32'(wben_o_wb), 32'd0);
      chk("tmo_req", 32'(dmem_req), 32'd0);
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      chk("late_ack_wben", 32'(wben_o_wb), 32'd0);
      chk("late_ack_buserr", 32'(buserr_o), 32'd0);

      // Reset while the request is outstanding
      instr_i_mem = enc(7'b0000011, 3'b010, 5'd4); wbaddr_now_i_mem = 5'd4; alu_i_mem = 32'h200;
      @(posedge clk); #1;
      chk("rreq_req", 32'(dmem_req), 32'd1);
      chk("rreq_addr", dmem_addr, 32'h200);
      @(posedge clk); #1;
      rst = 1'b1; instr_i_mem = 32'h0;
      @(posedge clk); #1;
      chk("rreq_req_low", 32'(dmem_req), 32'd0);
      chk("rreq_stall", 32'(stall_o), 32'd0);
      chk("rreq_addr0", dmem_addr, 32'h0);
      chk("rreq_wbdata", wbdata_o_wb, 32'h0);
      rst = 1'b0;

      // JAL with rd=1, then rd=0, then canonical NOP
      alu_op(enc(7'b1101111, 3'b000, 5'd1), 5'd1, 32'h999, 32'h44);
      chk("jal_wbdata", wbdata_o_wb, 32'h44);
      chk("jal_wben", 32'(wben_o_wb), 32'd1);
      alu_op(enc(7'b1101111, 3'b000, 5'd0), 5'd0, 32'h999, 32'h44);
      chk("jal_x0_wben", 32'(wben_o_wb), 32'd0);
      alu_op(32'h0000_0013, 5'd0, 32'h0, 32'h0);
      chk("nop_wben", 32'(wben_o_wb), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
